write_pack: RTL and testbench

WRITE_PACK -- requirements
Module: write_pack

---
 rtl/write_pack.sv | 173 +++++++++++++++++
 tb/tb_write_pack.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_pack.sv
// write_pack: clips signed input values, packs GROUP_SIZE of them per memory
// word and emits one write per completed word to consecutive addresses.
// A job is num_iters * num_reads_per_iter words starting at base_address.
module write_pack #(
    parameter int GROUP_SIZE             = 2,
    parameter int INPUT_DATA_WIDTH       = 32,
    parameter int OUTPUT_DATA_WIDTH      = 8,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS        = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       configure,
    input  logic [LOG_MAX_ITERS-1:0]                   num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]          num_reads_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]                 base_address,
    input  logic signed [INPUT_DATA_WIDTH-1:0]         min_clip,
    input  logic signed [INPUT_DATA_WIDTH-1:0]         max_clip,
    input  logic signed [INPUT_DATA_WIDTH-1:0]         data_in,
    input  logic                                       valid_in,
    output logic                                       avail_out,
    output logic [GROUP_SIZE*OUTPUT_DATA_WIDTH-1:0]    data_out,
    output logic [LOG_MAX_ADDRESS-1:0]                 address_out,
    output logic                                       valid_out,
    output logic                                       done
);

    localparam int EW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam int OW = OUTPUT_DATA_WIDTH;

    localparam logic [EW-1:0]                     ELEM_LAST = EW'(GROUP_SIZE - 1);
    localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE  = 1;
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE  = 1;
    localparam logic [LOG_MAX_ADDRESS-1:0]        ADDR_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t state, state_n;

    // latched job configuration
    logic [LOG_MAX_ITERS-1:0]          cfg_iters;
    logic [LOG_MAX_READS_PER_ITER-1:0] cfg_reads;
    logic signed [INPUT_DATA_WIDTH-1:0] cfg_min, cfg_max;

    // progress counters; word_addr is the address of the word being built
    logic [EW-1:0]                     elem_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;
    logic [LOG_MAX_ITERS-1:0]          iter_cnt;
    logic [LOG_MAX_ADDRESS-1:0]        word_addr;

    logic [GROUP_SIZE-1:0][OW-1:0] pack_buf;
    logic [GROUP_SIZE-1:0][OW-1:0] word_next;

    logic signed [INPUT_DATA_WIDTH-1:0] clipped_full;
    logic [OW-1:0]                      clipped;

    logic accept, last_elem, last_read, last_iter, job_last;

    assign accept    = valid_in && avail_out;
    assign last_elem = (elem_cnt == ELEM_LAST);
    assign last_read = (read_cnt == cfg_reads - READ_ONE);
    assign last_iter = (iter_cnt == cfg_iters - ITER_ONE);
    assign job_last  = accept && last_elem && last_read && last_iter;

    // signed saturation to the latched bounds, then truncation to the packed width
    always_comb begin
        clipped_full = data_in;
        if (data_in < cfg_min)
            clipped_full = cfg_min;
        else if (data_in > cfg_max)
            clipped_full = cfg_max;
    end

    assign clipped = clipped_full[OW-1:0];

    // per-slot storage; the incoming value is merged into its slot so a word
    // completes on the same edge as its last element is accepted
    genvar k;
    generate
        for (k = 0; k < GROUP_SIZE; k++) begin : g_slot
            assign word_next[k] = (elem_cnt == EW'(k)) ? clipped : pack_buf[k];

            // capture an accepted element into its slot
            always_ff @(posedge clk) begin
                if (!rst)
                    pack_buf[k] <= '0;
                else if (accept && elem_cnt == EW'(k))
                    pack_buf[k] <= clipped;
            end
        end
    endgenerate

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next state and input handshake; configure restarts from any state
    always_comb begin
        state_n   = state;
        avail_out = (state == S_RUN);
        if (configure) begin
            if (num_iters == '0 || num_reads_per_iter == '0)
                state_n = S_FLUSH;
            else
                state_n = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (job_last) state_n = S_FLUSH;
                S_FLUSH: state_n = S_IDLE;
                default: state_n = state;
            endcase
        end
    end

    // configuration latch, counters and write port; a word completed on the
    // same edge as configure is still written with its old address
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_iters   <= '0;
            cfg_reads   <= '0;
            cfg_min     <= '0;
            cfg_max     <= '0;
            elem_cnt    <= '0;
            read_cnt    <= '0;
            iter_cnt    <= '0;
            word_addr   <= '0;
            data_out    <= '0;
            address_out <= '0;
            valid_out   <= 1'b0;
            done        <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= (state == S_FLUSH) && !configure;

            if (accept && last_elem) begin
                valid_out   <= 1'b1;
                data_out    <= word_next;
                address_out <= word_addr;
            end

            if (configure) begin
                cfg_iters <= num_iters;
                cfg_reads <= num_reads_per_iter;
                cfg_min   <= min_clip;
                cfg_max   <= max_clip;
                elem_cnt  <= '0;
                read_cnt  <= '0;
                iter_cnt  <= '0;
                word_addr <= base_address;
            end else if (accept) begin
                if (last_elem) begin
                    elem_cnt  <= '0;
                    word_addr <= word_addr + ADDR_ONE;
                    if (last_read) begin
                        read_cnt <= '0;
                        if (!last_iter)
                            iter_cnt <= iter_cnt + ITER_ONE;
                    end else begin
                        read_cnt <= read_cnt + READ_ONE;
                    end
                end else begin
                    elem_cnt <= elem_cnt + EW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_write_pack.sv
// Directed bench for write_pack with default parameters (2 x 8-bit per word).
module tb_write_pack;

    logic               clk = 1'b0;
    logic               rst;
    logic               configure;
    logic [15:0]        num_iters;
    logic [15:0]        num_reads_per_iter;
    logic [15:0]        base_address;
    logic signed [31:0] min_clip, max_clip, data_in;
    logic               valid_in;
    logic               avail_out;
    logic [15:0]        data_out;
    logic [15:0]        address_out;
    logic               valid_out;
    logic               done;

    int checks   = 0;
    int failures = 0;

    write_pack dut (
        .clk(clk), .rst(rst), .configure(configure),
        .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
        .base_address(base_address), .min_clip(min_clip), .max_clip(max_clip),
        .data_in(data_in), .valid_in(valid_in), .avail_out(avail_out),
        .data_out(data_out), .address_out(address_out),
        .valid_out(valid_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]        iters, reads, base;
        logic signed [31:0] mn, mx;
        int                 n_in;
        logic [3:0][31:0]   d;
        int                 n_wr;
        logic [1:0][15:0]   w;
        logic [1:0][15:0]   a;
    } vec_t;

    function automatic vec_t mk(int it, int rd, int base, int mn, int mx, int n_in,
                                int d0, int d1, int d2, int d3, int n_wr,
                                int w0, int a0, int w1, int a1);
        vec_t v;
        v.iters = 16'(it); v.reads = 16'(rd); v.base = 16'(base);
        v.mn = mn; v.mx = mx; v.n_in = n_in;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.n_wr = n_wr;
        v.w[0] = 16'(w0); v.a[0] = 16'(a0); v.w[1] = 16'(w1); v.a[1] = 16'(a1);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int it, input int rd, input int base, input int mn, input int mx);
        num_iters = 16'(it); num_reads_per_iter = 16'(rd); base_address = 16'(base);
        min_clip = mn; max_clip = mx;
    endtask

    // configure, stream the vector's inputs (optionally with gaps), check every
    // write, the done timing relative to the last write, and output hold
    task automatic run_vec(input vec_t v, input bit gaps);
        int fed = 0, wr = 0, cyc = 0, last_wr = -10, done_cyc = -1;
        set_cfg(v.iters, v.reads, v.base, v.mn, v.mx);
        configure = 1'b1; valid_in = 1'b0;
        step();
        configure = 1'b0;
        while (done_cyc < 0 && cyc < 60) begin
            if (avail_out && fed < v.n_in && (!gaps || $urandom_range(0, 2) != 0)) begin
                valid_in = 1'b1; data_in = v.d[fed]; fed++;
            end else if (!avail_out) begin
                valid_in = 1'b1; data_in = 32'sd99;   // must be ignored
            end else begin
                valid_in = 1'b0; data_in = 32'sd77;
            end
            step();
            cyc++;
            if (valid_out) begin
                if (wr < v.n_wr) begin
                    chk("wr_data", data_out, v.w[wr]);
                    chk("wr_addr", address_out, v.a[wr]);
                end else begin
                    chk("extra_write", 32'(wr), 32'(v.n_wr));
                end
                wr++;
                last_wr = cyc;
            end
            if (done) done_cyc = cyc;
        end
        valid_in = 1'b0;
        chk("write_count", 32'(wr), 32'(v.n_wr));
        if (done_cyc < 0) chk("done_timeout", 32'(cyc), 32'(0));
        else              chk("done_after_last_write", 32'(done_cyc), 32'(last_wr + 1));
        step();
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("hold_data", data_out, v.w[v.n_wr-1]);
        chk("hold_addr", address_out, v.a[v.n_wr-1]);
    endtask

    task automatic zero_job(input int it, input int rd);
        set_cfg(it, rd, 16'h55, -128, 127);
        configure = 1'b1; valid_in = 1'b1; data_in = 32'sd5;
        step();
        configure = 1'b0;
        chk("zero_avail_c1", 32'(avail_out), 0);
        chk("zero_done_c1", 32'(done), 0);
        chk("zero_valid_c1", 32'(valid_out), 0);
        step();
        chk("zero_done_c2", 32'(done), 1);
        chk("zero_avail_c2", 32'(avail_out), 0);
        chk("zero_valid_c2", 32'(valid_out), 0);
        step();
        chk("zero_done_c3", 32'(done), 0);
        valid_in = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = mk(1, 2, 'h10, -128, 127, 4, 1, 2, 3, 4, 2, 'h0201, 'h10, 'h0403, 'h11);
        vecs[1] = mk(1, 1, 0, 0, 100, 2, -5, 300, 0, 0, 1, 'h6400, 0, 0, 0);
        vecs[2] = mk(1, 1, 0, 0, 100, 2, 50, -1, 0, 0, 1, 'h0032, 0, 0, 0);
        vecs[3] = mk(2, 1, 'hFFFF, -128, 127, 4, 5, 6, -1, -128, 2, 'h0605, 'hFFFF, 'h80FF, 'h0000);
        vecs[4] = mk(1, 1, 3, -1000, 1000, 2, 200, -200, 0, 0, 1, 'h38C8, 3, 0, 0);
        vecs[5] = mk(2, 1, 'h100, -3, 3, 4, 3, -3, -4, 4, 2, 'hFD03, 'h100, 'h03FD, 'h101);
        vecs[6] = mk(1, 2, 'h10, -128, 127, 4, 1, 2, 3, 4, 2, 'h0201, 'h10, 'h0403, 'h11);

        rst = 1'b0; configure = 1'b0; valid_in = 1'b0; data_in = '0;
        set_cfg(0, 0, 0, 0, 0);
        step(); step();
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_avail", 32'(avail_out), 0);
        chk("rst_data", data_out, 0);
        chk("rst_addr", address_out, 0);
        rst = 1'b1;
        step();

        // table-driven jobs, odd entries with random valid_in gaps
        for (int i = 0; i < 7; i++) run_vec(vecs[i], (i % 2) == 1);

        // empty jobs
        zero_job(0, 5);
        zero_job(3, 0);

        // abort mid-group: old partial word must never be written
        set_cfg(1, 2, 'h50, -128, 127);
        configure = 1'b1; step(); configure = 1'b0;
        chk("abort_avail", 32'(avail_out), 1);
        valid_in = 1'b1; data_in = 32'sd9; step(); valid_in = 1'b0;
        chk("abort_no_write", 32'(valid_out), 0);
        run_vec(mk(1, 1, 'h20, -128, 127, 2, 1, 2, 0, 0, 1, 'h0201, 'h20, 0, 0), 1'b0);

        // configure on the final accept: word still written, no done for old job
        set_cfg(1, 1, 'h30, -128, 127);
        configure = 1'b1; step(); configure = 1'b0;
        valid_in = 1'b1; data_in = 32'sd11; step();
        data_in = 32'sd12; configure = 1'b1; set_cfg(1, 1, 'h40, -128, 127);
        step();
        configure = 1'b0; valid_in = 1'b0;
        chk("race_valid", 32'(valid_out), 1);
        chk("race_data", data_out, 16'h0C0B);
        chk("race_addr", address_out, 16'h0030);
        chk("race_avail", 32'(avail_out), 1);
        chk("race_done_c1", 32'(done), 0);
        step();
        chk("race_done_c2", 32'(done), 0);
        chk("race_valid_c2", 32'(valid_out), 0);
        valid_in = 1'b1; data_in = 32'sd7; step();
        data_in = 32'sd8; step();
        valid_in = 1'b0;
        chk("race_new_valid", 32'(valid_out), 1);
        chk("race_new_data", data_out, 16'h0807);
        chk("race_new_addr", address_out, 16'h0040);
        step();
        chk("race_new_done", 32'(done), 1);
        step();

        // reset mid-job takes priority over configure and valid_in
        set_cfg(2, 2, 'h70, -128, 127);
        configure = 1'b1; step(); configure = 1'b0;
        valid_in = 1'b1; data_in = 32'sd1; step();
        valid_in = 1'b0; step();
        valid_in = 1'b1; data_in = 32'sd2; step();
        chk("pre_rst_data", data_out, 16'h0201);
        chk("pre_rst_addr", address_out, 16'h0070);
        data_in = 32'sd3; step();
        rst = 1'b0; configure = 1'b1; data_in = 32'sd4;
        step();
        rst = 1'b1; configure = 1'b0;
        chk("mid_rst_valid", 32'(valid_out), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_avail", 32'(avail_out), 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_addr", address_out, 0);
        for (int i = 0; i < 3; i++) begin
            data_in = 32'(i + 20);
            step();
            chk("idle_avail", 32'(avail_out), 0);
            chk("idle_valid", 32'(valid_out), 0);
            chk("idle_done", 32'(done), 0);
        end
        valid_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
